fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter for the async FIFO's write domain. Shares one

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 86 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle shared by the requesters, the round-robin arbiter and the FIFO write port.
// The arbiter side is the master; the requesters and the FIFO together form the slave side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  full;
  logic                  overflow;
  logic [NREQ-1:0]       gnt;
  logic                  wr_en;
  logic [WIDTH-1:0]      wdata;

  modport master (
    input  req, req_data, full, overflow,
    output gnt, wr_en, wdata
  );

  modport slave (
    output req, req_data, full, overflow,
    input  gnt, wr_en, wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the async FIFO: grants bursts of up to
// MAX_BURST words per requester, honours full, latches overflow and counts accepted writes.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    wr_clk,
  input  logic                    rst,
  fifo_wr_arbiter_if.master       bus,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    ovf_err,
  output logic [15:0]             wr_count
);
  localparam int         OW        = $clog2(NREQ);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t        state;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] next_owner;
  logic [7:0]    burst_cnt;
  logic          accept;

  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return OW'(sum);
  endfunction

  // Scan from the far end back toward rr_ptr so the closest requester wins.
  always_comb begin
    next_owner = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(rr_ptr, i)]) next_owner = wrap_add(rr_ptr, i);
    end
  end

  assign accept    = (state == BURST) && bus.req[owner] && !bus.full;
  assign bus.wr_en = accept;
  assign bus.wdata = accept ? bus.req_data[int'(owner)*WIDTH +: WIDTH] : '0;

  always_comb begin
    bus.gnt = '0;
    if (accept) bus.gnt[owner] = 1'b1;
  end

  // A stall on full leaves owner and burst_cnt untouched, so the burst budget survives it.
  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      ovf_err   <= 1'b0;
      wr_count  <= '0;
    end else begin
      ovf_err <= ovf_err | bus.overflow;
      case (state)
        ARB: begin
          if (|bus.req) begin
            owner     <= next_owner;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 8'd1;
            wr_count  <= wr_count + 16'd1;
            if (burst_cnt == LAST_BEAT) begin
              rr_ptr <= wrap_add(owner, 1);
              state  <= ARB;
            end
          end else if (!bus.req[owner]) begin
            rr_ptr <= wrap_add(owner, 1);
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: rotation, single requester, full stalls, early
// request drop, sticky overflow, asynchronous reset and write-counter wrap.
module tb_fifo_wr_arbiter;
  logic wr_clk;
  logic rst;
  logic rst2;
  logic [1:0]  owner;
  logic        ovf_err;
  logic [15:0] wr_count;
  logic [0:0]  owner2;
  logic        ovf_err2;
  logic [15:0] wr_count2;

  int errors = 0;
  int checks = 0;
  logic [3:0] word_cnt [4];

  fifo_wr_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();
  fifo_wr_arbiter_if #(.WIDTH(8), .NREQ(2)) bus2 ();

  fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
    .wr_clk   (wr_clk),
    .rst      (rst),
    .bus      (bus),
    .owner    (owner),
    .ovf_err  (ovf_err),
    .wr_count (wr_count)
  );

  // Long-burst instance used only to reach the 16-bit counter wrap in few cycles.
  fifo_wr_arbiter #(.WIDTH(8), .NREQ(2), .MAX_BURST(255)) dut_wrap (
    .wr_clk   (wr_clk),
    .rst      (rst2),
    .bus      (bus2),
    .owner    (owner2),
    .ovf_err  (ovf_err2),
    .wr_count (wr_count2)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 4; i++) word_cnt[i] = 4'd0;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic f, input logic o);
    bus.req      = r;
    bus.full     = f;
    bus.overflow = o;
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = {4'(i), word_cnt[i]};
  endtask

  // Drive one cycle, check the combinational outputs mid-cycle, then advance past the edge.
  task automatic runCycle(input logic [3:0] r, input logic f, input logic o,
                          input logic [3:0] exp_gnt, input logic [7:0] exp_wdata, input string tag);
    logic [3:0] g;
    applyStimulus(r, f, o);
    @(negedge wr_clk);
    checkOutput({tag, "/gnt"},   32'(bus.gnt),   32'(exp_gnt));
    checkOutput({tag, "/wr_en"}, 32'(bus.wr_en), 32'(|exp_gnt));
    checkOutput({tag, "/wdata"}, 32'(bus.wdata), 32'(exp_wdata));
    g = bus.gnt;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++) if (g[i]) word_cnt[i] = word_cnt[i] + 4'd1;
  endtask

  initial begin
    int n;
    bit seen_ffff;
    logic [3:0] eg;
    logic [7:0] ed;

    rst  = 1'b0;
    rst2 = 1'b0;
    clearCounts();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    bus2.req      = 2'b00;
    bus2.req_data = 16'hB2A1;
    bus2.full     = 1'b0;
    bus2.overflow = 1'b0;
    #2;
    checkOutput("reset/gnt",      32'(bus.gnt),   32'd0);
    checkOutput("reset/wr_en",    32'(bus.wr_en), 32'd0);
    checkOutput("reset/owner",    32'(owner),     32'd0);
    checkOutput("reset/wr_count", 32'(wr_count),  32'd0);
    checkOutput("reset/ovf_err",  32'(ovf_err),   32'd0);
    @(negedge wr_clk);
    rst = 1'b1;
    @(posedge wr_clk);
    #1;

    $display("[TB] all four requesting, bursts of 4 in rotation");
    for (int c = 0; c < 20; c++) begin
      eg = (c % 5 == 0) ? 4'd0 : 4'(1 << (c / 5));
      ed = (c % 5 == 0) ? 8'd0 : {4'(c / 5), 4'(c % 5 - 1)};
      runCycle(4'b1111, 1'b0, 1'b0, eg, ed, $sformatf("rr4 c%0d", c));
    end
    checkOutput("rr4/wr_count", 32'(wr_count), 32'd16);

    $display("[TB] single requester 2 wraps around");
    clearCounts();
    for (int c = 0; c < 10; c++) begin
      eg = (c % 5 == 0) ? 4'd0 : 4'b0100;
      ed = (c % 5 == 0) ? 8'd0 : {4'd2, 4'(c - 1 - c / 5)};
      runCycle(4'b0100, 1'b0, 1'b0, eg, ed, $sformatf("single c%0d", c));
      checkOutput($sformatf("single c%0d/owner", c), 32'(owner), 32'd2);
    end
    checkOutput("single/wr_count", 32'(wr_count), 32'd24);

    $display("[TB] full stall after second write");
    clearCounts();
    runCycle(4'b0001, 1'b0, 1'b0, 4'b0000, 8'h00, "full c0");
    runCycle(4'b0001, 1'b0, 1'b0, 4'b0001, 8'h00, "full c1");
    runCycle(4'b0001, 1'b0, 1'b0, 4'b0001, 8'h01, "full c2");
    runCycle(4'b0001, 1'b1, 1'b0, 4'b0000, 8'h00, "full c3");
    runCycle(4'b0001, 1'b1, 1'b0, 4'b0000, 8'h00, "full c4");
    runCycle(4'b0001, 1'b1, 1'b0, 4'b0000, 8'h00, "full c5");
    runCycle(4'b0001, 1'b0, 1'b0, 4'b0001, 8'h02, "full c6");
    runCycle(4'b0001, 1'b0, 1'b0, 4'b0001, 8'h03, "full c7");
    runCycle(4'b0001, 1'b0, 1'b0, 4'b0000, 8'h00, "full c8");
    runCycle(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, "full c9");
    checkOutput("full/wr_count", 32'(wr_count), 32'd28);

    $display("[TB] requester 1 drops after one word");
    clearCounts();
    runCycle(4'b0110, 1'b0, 1'b0, 4'b0000, 8'h00, "drop c0");
    runCycle(4'b0110, 1'b0, 1'b0, 4'b0010, 8'h10, "drop c1");
    runCycle(4'b0100, 1'b0, 1'b0, 4'b0000, 8'h00, "drop c2");
    runCycle(4'b0100, 1'b0, 1'b0, 4'b0000, 8'h00, "drop c3");
    checkOutput("drop/owner", 32'(owner), 32'd2);
    runCycle(4'b0100, 1'b0, 1'b0, 4'b0100, 8'h20, "drop c4");
    runCycle(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, "drop c5");
    checkOutput("drop/wr_count", 32'(wr_count), 32'd30);

    $display("[TB] overflow pulse is sticky");
    checkOutput("ovf/before", 32'(ovf_err), 32'd0);
    runCycle(4'b0000, 1'b0, 1'b1, 4'b0000, 8'h00, "ovf c0");
    for (int c = 1; c < 4; c++) begin
      runCycle(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, $sformatf("ovf c%0d", c));
      checkOutput($sformatf("ovf c%0d/ovf_err", c), 32'(ovf_err), 32'd1);
    end

    $display("[TB] asynchronous reset in the middle of a burst");
    clearCounts();
    runCycle(4'b1111, 1'b0, 1'b0, 4'b0000, 8'h00, "rst c0");
    runCycle(4'b1111, 1'b0, 1'b0, 4'b1000, 8'h30, "rst c1");
    runCycle(4'b1111, 1'b0, 1'b0, 4'b1000, 8'h31, "rst c2");
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("rst/pre_wr_en", 32'(bus.wr_en), 32'd1);
    @(negedge wr_clk);
    rst = 1'b0;
    #1;
    checkOutput("rst/gnt",      32'(bus.gnt),   32'd0);
    checkOutput("rst/wr_en",    32'(bus.wr_en), 32'd0);
    checkOutput("rst/wdata",    32'(bus.wdata), 32'd0);
    checkOutput("rst/owner",    32'(owner),     32'd0);
    checkOutput("rst/wr_count", 32'(wr_count),  32'd0);
    checkOutput("rst/ovf_err",  32'(ovf_err),   32'd0);
    #1;
    rst = 1'b1;
    @(posedge wr_clk);
    #1;
    clearCounts();
    runCycle(4'b1111, 1'b0, 1'b0, 4'b0001, 8'h00, "rst restart");
    checkOutput("rst/restart_owner", 32'(owner), 32'd0);

    $display("[TB] write counter wrap on the long-burst instance");
    bus2.req = 2'b01;
    @(negedge wr_clk);
    rst2 = 1'b1;
    n = 0;
    seen_ffff = 1'b0;
    for (int cyc = 0; cyc < 70000 && n < 65537; cyc++) begin
      @(negedge wr_clk);
      if (n == 65535 && !seen_ffff) begin
        seen_ffff = 1'b1;
        checkOutput("wrap/ffff", 32'(wr_count2), 32'h0000FFFF);
      end
      if (bus2.wr_en) n++;
    end
    checkOutput("wrap/writes_seen", 32'(n), 32'd65537);
    @(posedge wr_clk);
    #1;
    checkOutput("wrap/wr_count", 32'(wr_count2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
